polygon_fit_scorer: RTL

Per-frame pose scorer between the pixel classification stage (polygon membership plus chroma-key background flag) and the game state FSM. On a start pulse it waits for the next frame boundary, then counts classified pixels over exactly one frame. At the following boundary it reduces the counts to a signed 13-bit score and a pass flag, which the FSM uses to drive text and buzzer feedback.

---
 rtl/polygon_fit_scorer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/polygon_fit_scorer.sv
// ---------------------------------------------------------------------------
// polygon_fit_scorer
//
// Per-frame pose scorer. After a start request it waits for the next frame
// boundary and then accumulates classified pixels for exactly one frame.
// At the closing boundary it reduces the three pixel counts to a signed
// 13-bit score and a pass flag.
//
// Parameters
//   SHIFT    arithmetic right shift applied to the raw difference
//   PASS_TH  signed threshold, pass = (score >= PASS_TH)
//
// Ports
//   clk               system clock
//   reset             asynchronous reset, active low
//   pix_en            one-cycle pixel strobe
//   DE                active-video flag, aligned with pixel inputs
//   v_sync            vertical sync, active-low pulse
//   in_polygon        pixel lies inside the target polygon
//   in_polygon_valid  qualifier for in_polygon
//   chroma            1 = background key colour, 0 = player body
//   start             measurement request, level sampled every clk
//   busy              high from accepted start until result_valid
//   score             signed 13-bit result, held until the next result
//   pass              score >= PASS_TH, held with score
//   result_valid      one-cycle pulse when score/pass update
// ---------------------------------------------------------------------------
module polygon_fit_scorer #(
    parameter int SHIFT   = 6,
    parameter int PASS_TH = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        DE,
    input  logic        v_sync,
    input  logic        in_polygon,
    input  logic        in_polygon_valid,
    input  logic        chroma,
    input  logic        start,
    output logic        busy,
    output logic [12:0] score,
    output logic        pass,
    output logic        result_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_ACCUM = 3'd2,
        S_SUM   = 3'd3,
        S_SCALE = 3'd4
    } state_t;

    localparam logic [18:0]        CNT_MAX   = 19'h7FFFF;
    localparam logic signed [20:0] SCORE_MAX = 21'sd4095;
    localparam logic signed [20:0] SCORE_MIN = -21'sd4096;
    localparam logic signed [20:0] PASS_TH_W = 21'(PASS_TH);

    state_t             state_q, state_d;
    logic               v_sync_d_q;
    logic               fb;
    logic               q;
    logic [2:0]         cls;
    logic [18:0]        hit_cnt, miss_cnt, hole_cnt;
    logic signed [20:0] diff_q, diff_d;
    logic signed [20:0] shifted;
    logic signed [20:0] clamped;
    logic [12:0]        score_q, score_d;
    logic               pass_q, pass_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;

    // Falling edge of v_sync marks the frame boundary.
    assign fb = v_sync_d_q & ~v_sync;
    assign q  = pix_en & DE & in_polygon_valid;

    // Class vector: [0]=hit, [1]=miss, [2]=hole. Background outside the
    // polygon is deliberately not counted.
    always_comb begin
        cls    = '0;
        cls[0] = q &  in_polygon & ~chroma;
        cls[1] = q & ~in_polygon & ~chroma;
        cls[2] = q &  in_polygon &  chroma;
    end

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ARM;
            // An fb coinciding with start is seen while still IDLE, so it
            // cannot arm accumulation; counting waits for the next fb.
            S_ARM:   if (fb) state_d = S_ACCUM;
            S_ACCUM: if (fb) state_d = S_SUM;
            S_SUM:   state_d = S_SCALE;
            S_SCALE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Saturating class counters, cleared when a start is accepted.
    // The pixel sampled on the closing fb cycle is excluded.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [18:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (state_q == S_IDLE && start) begin
                    cnt_d = '0;
                end else if (state_q == S_ACCUM && !fb && cls[gi] &&
                             cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 19'd1;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign hit_cnt  = g_cnt[0].cnt_q;
    assign miss_cnt = g_cnt[1].cnt_q;
    assign hole_cnt = g_cnt[2].cnt_q;

    // -----------------------------------------------------------------------
    // Reduction: diff is 21-bit signed, wide enough for the full range of
    // hit - miss - hole/2 with all counters saturated.
    // -----------------------------------------------------------------------
    always_comb begin
        diff_d = diff_q;
        if (state_q == S_SUM) begin
            diff_d = $signed({2'b00, hit_cnt})
                   - $signed({2'b00, miss_cnt})
                   - $signed({3'b000, hole_cnt[18:1]});
        end
    end

    always_comb begin
        shifted = diff_q >>> SHIFT;
        if (shifted > SCORE_MAX) begin
            clamped = SCORE_MAX;
        end else if (shifted < SCORE_MIN) begin
            clamped = SCORE_MIN;
        end else begin
            clamped = shifted;
        end
    end

    always_comb begin
        score_d        = score_q;
        pass_d         = pass_q;
        result_valid_d = 1'b0;
        if (state_q == S_SCALE) begin
            score_d        = clamped[12:0];
            pass_d         = (clamped >= PASS_TH_W);
            result_valid_d = 1'b1;
        end
    end

    // busy follows the next state so it rises with ARM and falls in the
    // same cycle result_valid is presented.
    assign busy_d = (state_d != S_IDLE);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            // Reset high: a v_sync already low at release can at most yield
            // one fb on the first cycle, which lands in IDLE and is ignored.
            v_sync_d_q     <= 1'b1;
            diff_q         <= '0;
            score_q        <= '0;
            pass_q         <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            v_sync_d_q     <= v_sync;
            diff_q         <= diff_d;
            score_q        <= score_d;
            pass_q         <= pass_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign score        = score_q;
    assign pass         = pass_q;
    assign result_valid = result_valid_q;

endmodule
